// File: rtl/datapath.sv
// Datapath: 8x16 register file feeding operand registers A/B, a shifter on B,
// a 4-function ALU, and result/status registers C/Z.
module datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] datapath_in,
    input  logic        vsel,
    input  logic [2:0]  writenum,
    input  logic        write,
    input  logic [2:0]  readnum,
    input  logic        loada,
    input  logic        loadb,
    input  logic [1:0]  shift,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  ALUop,
    input  logic        loadc,
    input  logic        loads,
    output logic [15:0] datapath_out,
    output logic        Z_out
);

    logic [15:0] regs_q [8];
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic        z_q, z_d;

    logic [15:0] data_in;
    logic [15:0] read_data;
    logic [15:0] shift_out;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_out;
    logic        alu_zero;

    assign data_in   = vsel ? datapath_in : c_q;
    assign read_data = regs_q[readnum];

    always_comb begin
        shift_out = b_q;
        unique case (shift)
            2'b00: shift_out = b_q;
            2'b01: shift_out = {b_q[14:0], 1'b0};
            2'b10: shift_out = {1'b0, b_q[15:1]};
            2'b11: shift_out = {b_q[15], b_q[15:1]};
        endcase
    end

    assign ain = asel ? '0 : a_q;
    assign bin = bsel ? datapath_in : shift_out;

    always_comb begin
        alu_out = '0;
        unique case (ALUop)
            2'b00: alu_out = ain + bin;
            2'b01: alu_out = ain - bin;
            2'b10: alu_out = ain & bin;
            2'b11: alu_out = ~bin;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    always_comb begin
        a_d = loada ? read_data : a_q;
        b_d = loadb ? read_data : b_q;
        c_d = loadc ? alu_out   : c_q;
        z_d = loads ? alu_zero  : z_q;
    end

    // Reads see pre-edge contents, so a same-cycle write/read returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write) begin
            regs_q[writenum] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign datapath_out = c_q;
    assign Z_out        = z_q;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: hand-computed vectors checked
// with immediate assertions after each register-to-register step.
module tb_datapath;

    logic        clk;
    logic        rst_n;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] datapath_out;
    logic        Z_out;

    int n_cmp;
    int n_mis;

    datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .datapath_in  (datapath_in),
        .vsel         (vsel),
        .writenum     (writenum),
        .write        (write),
        .readnum      (readnum),
        .loada        (loada),
        .loadb        (loadb),
        .shift        (shift),
        .asel         (asel),
        .bsel         (bsel),
        .ALUop        (ALUop),
        .loadc        (loadc),
        .loads        (loads),
        .datapath_out (datapath_out),
        .Z_out        (Z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        datapath_in = '0;
        vsel = 1'b0; writenum = '0; write = 1'b0; readnum = '0;
        loada = 1'b0; loadb = 1'b0; shift = 2'b00; asel = 1'b0; bsel = 1'b0;
        ALUop = 2'b00; loadc = 1'b0; loads = 1'b0;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr_imm(input logic [2:0] n, input logic [15:0] v);
        idle();
        vsel = 1'b1; write = 1'b1; writenum = n; datapath_in = v;
        tick();
        idle();
    endtask

    task automatic wr_back(input logic [2:0] n);
        idle();
        vsel = 1'b0; write = 1'b1; writenum = n;
        tick();
        idle();
    endtask

    task automatic ld_a(input logic [2:0] n);
        idle();
        readnum = n; loada = 1'b1;
        tick();
        idle();
    endtask

    task automatic ld_b(input logic [2:0] n);
        idle();
        readnum = n; loadb = 1'b1;
        tick();
        idle();
    endtask

    task automatic alu(input logic as, input logic bs, input logic [1:0] sh,
                       input logic [1:0] op, input logic [15:0] din);
        idle();
        asel = as; bsel = bs; shift = sh; ALUop = op; datapath_in = din;
        loadc = 1'b1; loads = 1'b1;
        tick();
        idle();
    endtask

    task automatic readback(input string tag, input logic [2:0] n, input logic [15:0] exp);
        ld_b(n);
        alu(1'b1, 1'b0, 2'b00, 2'b00, 16'h0);
        chk16(tag, datapath_out, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        idle();
        rst_n = 1'b0;
        #12;
        chk16("reset_out", datapath_out, 16'h0000);
        chk1 ("reset_z", Z_out, 1'b0);
        #3 rst_n = 1'b1;
        tick();

        // Load and readback
        wr_imm(3'd0, 16'd1);
        wr_imm(3'd1, 16'd8);
        readback("rb_r0", 3'd0, 16'd1);
        chk1("rb_r0_z", Z_out, 1'b0);
        readback("rb_r1", 3'd1, 16'd8);
        chk1("rb_r1_z", Z_out, 1'b0);

        // Arithmetic with write-back through C
        ld_a(3'd1); ld_b(3'd0);
        alu(1'b0, 1'b0, 2'b00, 2'b00, 16'h0);
        chk16("add", datapath_out, 16'd9);
        chk1 ("add_z", Z_out, 1'b0);
        wr_back(3'd2);
        readback("add_wb", 3'd2, 16'd9);

        ld_a(3'd1); ld_b(3'd0);
        alu(1'b0, 1'b0, 2'b00, 2'b01, 16'h0);
        chk16("sub", datapath_out, 16'd7);
        wr_back(3'd2);
        readback("sub_wb", 3'd2, 16'd7);

        ld_a(3'd1); ld_b(3'd0);
        alu(1'b0, 1'b0, 2'b00, 2'b10, 16'h0);
        chk16("and", datapath_out, 16'd0);
        chk1 ("and_z", Z_out, 1'b1);
        wr_back(3'd2);
        readback("and_wb", 3'd2, 16'd0);

        // Simultaneous A/B load from r1: 8 + 8
        idle();
        readnum = 3'd1; loada = 1'b1; loadb = 1'b1;
        tick();
        alu(1'b0, 1'b0, 2'b00, 2'b00, 16'h0);
        chk16("ab_same", datapath_out, 16'd16);

        // NOT
        ld_b(3'd0);
        alu(1'b1, 1'b0, 2'b00, 2'b11, 16'h0);
        chk16("not", datapath_out, 16'hFFFE);
        chk1 ("not_z", Z_out, 1'b0);

        // Shifter
        ld_b(3'd1);
        alu(1'b1, 1'b0, 2'b01, 2'b00, 16'h0);
        chk16("shl", datapath_out, 16'd16);
        alu(1'b1, 1'b0, 2'b10, 2'b00, 16'h0);
        chk16("shr", datapath_out, 16'd4);
        wr_imm(3'd3, 16'h8000);
        ld_b(3'd3);
        alu(1'b1, 1'b0, 2'b11, 2'b00, 16'h0);
        chk16("sra", datapath_out, 16'hC000);
        alu(1'b1, 1'b0, 2'b10, 2'b00, 16'h0);
        chk16("shr_msb", datapath_out, 16'h4000);
        alu(1'b1, 1'b0, 2'b01, 2'b00, 16'h0);
        chk16("shl_wrap", datapath_out, 16'h0000);

        // Immediate B operand; SUB wraps mod 2^16
        ld_a(3'd0);
        alu(1'b0, 1'b1, 2'b00, 2'b00, 16'd4);
        chk16("imm_add", datapath_out, 16'd5);
        chk1 ("imm_z", Z_out, 1'b0);
        alu(1'b0, 1'b1, 2'b00, 2'b01, 16'd3);
        chk16("sub_wrap", datapath_out, 16'hFFFE);

        // Independent C/Z loads: Z only, then C only
        idle();
        asel = 1'b1; bsel = 1'b1; datapath_in = 16'h0; loads = 1'b1;
        tick();
        chk1 ("zonly_z", Z_out, 1'b1);
        chk16("zonly_c", datapath_out, 16'hFFFE);
        idle();
        asel = 1'b1; bsel = 1'b1; datapath_in = 16'h0077; loadc = 1'b1;
        tick();
        idle();
        chk16("conly_c", datapath_out, 16'h0077);
        chk1 ("conly_z", Z_out, 1'b1);

        // Same-cycle write and read of r4 returns the old value
        wr_imm(3'd4, 16'h1234);
        idle();
        vsel = 1'b1; write = 1'b1; writenum = 3'd4; datapath_in = 16'h5555;
        readnum = 3'd4; loadb = 1'b1;
        tick();
        alu(1'b1, 1'b0, 2'b00, 2'b00, 16'h0);
        chk16("rw_old", datapath_out, 16'h1234);
        readback("rw_new", 3'd4, 16'h5555);

        // Asynchronous reset mid-cycle with C and Z nonzero
        wr_imm(3'd5, 16'hABCD);
        wr_imm(3'd7, 16'h00FF);
        idle();
        asel = 1'b1; bsel = 1'b1; datapath_in = 16'h0; loads = 1'b1;
        tick();
        idle();
        chk1 ("pre_rst_z", Z_out, 1'b1);
        chk16("pre_rst_c", datapath_out, 16'h5555);
        #2 rst_n = 1'b0;
        #1;
        chk16("rst_out", datapath_out, 16'h0000);
        chk1 ("rst_z", Z_out, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            readback($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
